tlb_set_array: RTL and testbench



---
 rtl/tlb_set_array.sv | 216 +++++++++++++++++++++
 tb/tb_tlb_set_array.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_set_array.sv
// Set-associative TLB entry store: per-way tag/data storage with ASID and global
// tagging, saturating LRU age counters, a combinational victim pick for the read
// set, and a flush engine that walks sets one per cycle.
module tlb_set_array #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned VPN_W    = 20,
  parameter int unsigned PPN_W    = 20,
  parameter int unsigned PERM_W   = 2,
  parameter int unsigned ASID_W   = 8,
  parameter int unsigned LRU_BITS = 4,
  localparam int unsigned SET_W   = $clog2(NUM_SETS),
  localparam int unsigned WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SET_W-1:0]             rd_set,
  output logic [NUM_WAYS-1:0]          rd_valid,
  output logic [NUM_WAYS-1:0]          rd_global,
  output logic [NUM_WAYS*VPN_W-1:0]    rd_vpn,
  output logic [NUM_WAYS*PPN_W-1:0]    rd_ppn,
  output logic [NUM_WAYS*PERM_W-1:0]   rd_perms,
  output logic [NUM_WAYS*ASID_W-1:0]   rd_asid,
  output logic [NUM_WAYS*LRU_BITS-1:0] rd_lru,
  output logic [WAY_W-1:0]             victim_way,
  input  logic                         wr_en,
  input  logic [SET_W-1:0]             wr_set,
  input  logic [WAY_W-1:0]             wr_way,
  input  logic [VPN_W-1:0]             wr_vpn,
  input  logic [PPN_W-1:0]             wr_ppn,
  input  logic [PERM_W-1:0]            wr_perms,
  input  logic [ASID_W-1:0]            wr_asid,
  input  logic                         wr_global,
  input  logic                         touch_en,
  input  logic [SET_W-1:0]             touch_set,
  input  logic [WAY_W-1:0]             touch_way,
  input  logic                         flush_req,
  input  logic [1:0]                   flush_mode,
  input  logic [ASID_W-1:0]            flush_asid,
  input  logic [SET_W-1:0]             flush_set,
  output logic                         ready,
  output logic                         flush_busy,
  output logic                         flush_done
);

  localparam logic [LRU_BITS-1:0] AMAX = {LRU_BITS{1'b1}};

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  state_e              state_q, state_d;
  logic [SET_W-1:0]    ptr_q, ptr_d;
  logic [1:0]          mode_q, mode_d;
  logic [ASID_W-1:0]   fasid_q, fasid_d;

  logic                valid_q [NUM_SETS][NUM_WAYS];
  logic                valid_d [NUM_SETS][NUM_WAYS];
  logic [LRU_BITS-1:0] lru_q   [NUM_SETS][NUM_WAYS];
  logic [LRU_BITS-1:0] lru_d   [NUM_SETS][NUM_WAYS];
  logic                glob_q  [NUM_SETS][NUM_WAYS];
  logic [VPN_W-1:0]    vpn_q   [NUM_SETS][NUM_WAYS];
  logic [PPN_W-1:0]    ppn_q   [NUM_SETS][NUM_WAYS];
  logic [PERM_W-1:0]   perms_q [NUM_SETS][NUM_WAYS];
  logic [ASID_W-1:0]   asid_q  [NUM_SETS][NUM_WAYS];

  logic                wr_acc, touch_acc;
  logic                vic_found;
  logic [LRU_BITS-1:0] vic_best;

  function automatic logic [LRU_BITS-1:0] sat_inc(input logic [LRU_BITS-1:0] v);
    return (v == AMAX) ? v : v + 1'b1;
  endfunction

  assign ready      = (state_q != StWalk);
  assign flush_busy = (state_q == StWalk);
  assign flush_done = (state_q == StDone);

  assign wr_acc    = wr_en & ready;
  // A touch sharing its set with an accepted write is dropped.
  assign touch_acc = touch_en & ready & valid_q[touch_set][touch_way] &
                     ~(wr_acc & (wr_set == touch_set));

  // Flush FSM next-state: latch request, walk sets, pulse done.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    fasid_d = fasid_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (flush_req) begin
          mode_d  = flush_mode;
          fasid_d = flush_asid;
          ptr_d   = flush_mode[1] ? flush_set : '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (mode_q[1] || (ptr_q == SET_W'(NUM_SETS - 1))) state_d = StDone;
        // Whole-array walks wrap the pointer back to 0 on exit.
        if (!mode_q[1]) ptr_d = ptr_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Valid/LRU next-state from write, touch and the flush walk.
  always_comb begin
    valid_d = valid_q;
    lru_d   = lru_q;
    if (wr_acc) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == wr_way) begin
          valid_d[wr_set][w] = 1'b1;
          lru_d[wr_set][w]   = '0;
        end else if (valid_q[wr_set][w]) begin
          lru_d[wr_set][w] = sat_inc(lru_q[wr_set][w]);
        end
      end
    end
    if (touch_acc) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == touch_way) begin
          lru_d[touch_set][w] = '0;
        end else if (valid_q[touch_set][w]) begin
          lru_d[touch_set][w] = sat_inc(lru_q[touch_set][w]);
        end
      end
    end
    if (state_q == StWalk) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (!mode_q[0] || ((asid_q[ptr_q][w] == fasid_q) && !glob_q[ptr_q][w])) begin
          valid_d[ptr_q][w] = 1'b0;
          lru_d[ptr_q][w]   = '0;
        end
      end
    end
  end

  // Control state, valid bits and age counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      mode_q  <= '0;
      fasid_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          lru_q[s][w]   <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      fasid_q <= fasid_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  // Entry payload storage; contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      vpn_q[wr_set][wr_way]   <= wr_vpn;
      ppn_q[wr_set][wr_way]   <= wr_ppn;
      perms_q[wr_set][wr_way] <= wr_perms;
      asid_q[wr_set][wr_way]  <= wr_asid;
      glob_q[wr_set][wr_way]  <= wr_global;
    end
  end

  // Combinational read of the whole selected set, way 0 at the LSBs.
  always_comb begin
    rd_valid  = '0;
    rd_global = '0;
    rd_vpn    = '0;
    rd_ppn    = '0;
    rd_perms  = '0;
    rd_asid   = '0;
    rd_lru    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_valid[w]                     = valid_q[rd_set][w];
      rd_global[w]                    = glob_q[rd_set][w];
      rd_vpn[w*VPN_W +: VPN_W]        = vpn_q[rd_set][w];
      rd_ppn[w*PPN_W +: PPN_W]        = ppn_q[rd_set][w];
      rd_perms[w*PERM_W +: PERM_W]    = perms_q[rd_set][w];
      rd_asid[w*ASID_W +: ASID_W]     = asid_q[rd_set][w];
      rd_lru[w*LRU_BITS +: LRU_BITS]  = lru_q[rd_set][w];
    end
  end

  // Victim: lowest invalid way, else oldest way with ties to the lowest index.
  always_comb begin
    victim_way = '0;
    vic_found  = 1'b0;
    vic_best   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!vic_found && !valid_q[rd_set][w]) begin
        victim_way = WAY_W'(w);
        vic_found  = 1'b1;
      end
    end
    if (!vic_found) begin
      vic_best = lru_q[rd_set][0];
      for (int w = 1; w < NUM_WAYS; w++) begin
        if (lru_q[rd_set][w] > vic_best) begin
          vic_best   = lru_q[rd_set][w];
          victim_way = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_set_array.sv
// Self-checking bench for tlb_set_array: constant vectors for the LRU sequence,
// hand sequences for flush timing/abort, and random traffic against a model.
module tb_tlb_set_array;
  localparam int NS = 16;
  localparam int NW = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rd_set;
  logic [3:0]  rd_valid, rd_global;
  logic [79:0] rd_vpn, rd_ppn;
  logic [7:0]  rd_perms;
  logic [31:0] rd_asid;
  logic [15:0] rd_lru;
  logic [1:0]  victim_way;
  logic        wr_en;
  logic [3:0]  wr_set;
  logic [1:0]  wr_way;
  logic [19:0] wr_vpn, wr_ppn;
  logic [1:0]  wr_perms;
  logic [7:0]  wr_asid;
  logic        wr_global;
  logic        touch_en;
  logic [3:0]  touch_set;
  logic [1:0]  touch_way;
  logic        flush_req;
  logic [1:0]  flush_mode;
  logic [7:0]  flush_asid;
  logic [3:0]  flush_set;
  logic        ready, flush_busy, flush_done;

  tlb_set_array #(
    .NUM_SETS(NS), .NUM_WAYS(NW), .VPN_W(20), .PPN_W(20), .PERM_W(2), .ASID_W(8), .LRU_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_set(rd_set), .rd_valid(rd_valid), .rd_global(rd_global),
    .rd_vpn(rd_vpn), .rd_ppn(rd_ppn), .rd_perms(rd_perms), .rd_asid(rd_asid), .rd_lru(rd_lru),
    .victim_way(victim_way), .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_vpn(wr_vpn),
    .wr_ppn(wr_ppn), .wr_perms(wr_perms), .wr_asid(wr_asid), .wr_global(wr_global),
    .touch_en(touch_en), .touch_set(touch_set), .touch_way(touch_way), .flush_req(flush_req),
    .flush_mode(flush_mode), .flush_asid(flush_asid), .flush_set(flush_set), .ready(ready),
    .flush_busy(flush_busy), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference model: plain arrays plus a queue of sets still to be flushed.
  bit          m_valid [NS][NW];
  int          m_lru   [NS][NW];
  bit   [19:0] m_vpn   [NS][NW];
  bit   [19:0] m_ppn   [NS][NW];
  bit   [1:0]  m_perms [NS][NW];
  bit   [7:0]  m_asid  [NS][NW];
  bit          m_glob  [NS][NW];
  int          m_q[$];
  bit          m_match;
  bit   [7:0]  m_fasid;
  bit          m_done;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          wr;
    bit          tc;
    logic [1:0]  way;
    logic [19:0] vpn;
    logic [3:0]  exp_valid;
    logic [15:0] exp_lru;
    logic [1:0]  exp_victim;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int age_up(input int a);
    return (a >= 15) ? 15 : a + 1;
  endfunction

  function automatic int m_victim(input int s);
    int best;
    for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
    best = 0;
    for (int w = 1; w < NW; w++) if (m_lru[s][w] > m_lru[s][best]) best = w;
    return best;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit nd;
    nd = 1'b0;
    if (!rst_n) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++) begin
          m_valid[s][w] = 1'b0;
          m_lru[s][w]   = 0;
        end
      m_q.delete();
      m_done = 1'b0;
      return;
    end
    if (m_q.size() != 0) begin
      int s;
      s = m_q.pop_front();
      for (int w = 0; w < NW; w++)
        if (!m_match || (m_asid[s][w] == m_fasid && !m_glob[s][w])) begin
          m_valid[s][w] = 1'b0;
          m_lru[s][w]   = 0;
        end
      if (m_q.size() == 0) nd = 1'b1;
    end else begin
      if (wr_en) begin
        for (int w = 0; w < NW; w++) begin
          if (w == int'(wr_way)) begin
            m_valid[wr_set][w] = 1'b1;
            m_lru[wr_set][w]   = 0;
            m_vpn[wr_set][w]   = wr_vpn;
            m_ppn[wr_set][w]   = wr_ppn;
            m_perms[wr_set][w] = wr_perms;
            m_asid[wr_set][w]  = wr_asid;
            m_glob[wr_set][w]  = wr_global;
          end else if (m_valid[wr_set][w]) begin
            m_lru[wr_set][w] = age_up(m_lru[wr_set][w]);
          end
        end
      end
      if (touch_en && m_valid[touch_set][touch_way] && !(wr_en && wr_set == touch_set)) begin
        for (int w = 0; w < NW; w++) begin
          if (w == int'(touch_way)) m_lru[touch_set][w] = 0;
          else if (m_valid[touch_set][w]) m_lru[touch_set][w] = age_up(m_lru[touch_set][w]);
        end
      end
      if (flush_req) begin
        m_match = flush_mode[0];
        m_fasid = flush_asid;
        if (flush_mode[1]) m_q.push_back(int'(flush_set));
        else for (int s = 0; s < NS; s++) m_q.push_back(s);
      end
    end
    m_done = nd;
  endtask

  // Compare every read-side output for the current rd_set against the model.
  task automatic cmp_model();
    logic [3:0]  ev, eg;
    logic [15:0] el;
    logic [79:0] evpn, eppn, mk20;
    logic [7:0]  eperm, mk2;
    logic [31:0] easid, mk8;
    int s;
    s = int'(rd_set);
    ev = '0; eg = '0; el = '0; evpn = '0; eppn = '0; mk20 = '0;
    eperm = '0; mk2 = '0; easid = '0; mk8 = '0;
    for (int w = 0; w < NW; w++) begin
      ev[w]          = m_valid[s][w];
      el[w*4 +: 4]   = 4'(m_lru[s][w]);
      if (m_valid[s][w]) begin
        mk20[w*20 +: 20] = '1;
        mk2[w*2 +: 2]    = '1;
        mk8[w*8 +: 8]    = '1;
        evpn[w*20 +: 20] = m_vpn[s][w];
        eppn[w*20 +: 20] = m_ppn[s][w];
        eperm[w*2 +: 2]  = m_perms[s][w];
        easid[w*8 +: 8]  = m_asid[s][w];
        eg[w]            = m_glob[s][w];
      end
    end
    check("m_valid", rd_valid, ev);
    check("m_lru", rd_lru, el);
    check("m_victim", victim_way, m_victim(s));
    check("m_vpn", rd_vpn & mk20, evpn);
    check("m_ppn", rd_ppn & mk20, eppn);
    check("m_perms", rd_perms & mk2, eperm);
    check("m_asid", rd_asid & mk8, easid);
    check("m_global", rd_global & ev, eg);
    check("m_ready", ready, m_q.size() == 0);
    check("m_busy", flush_busy, m_q.size() != 0);
    check("m_done", flush_done, m_done);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #2;
    cmp_model();
  endtask

  task automatic look(input int s);
    rd_set = 4'(s);
    #1;
    cmp_model();
  endtask

  task automatic idle();
    wr_en = 1'b0; touch_en = 1'b0; flush_req = 1'b0;
  endtask

  task automatic write(input int s, input int w, input logic [19:0] vpn, input logic [7:0] asid,
                       input logic glob);
    wr_en = 1'b1; wr_set = 4'(s); wr_way = 2'(w); wr_vpn = vpn; wr_ppn = vpn ^ 20'h5a5a5;
    wr_perms = vpn[1:0]; wr_asid = asid; wr_global = glob;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_at, nvalid;
    bit done_seen;

    vecs[0] = '{1, 0, 2'd0, 20'h11111, 4'b0001, 16'h0000, 2'd1};
    vecs[1] = '{1, 0, 2'd1, 20'h22222, 4'b0011, 16'h0001, 2'd2};
    vecs[2] = '{1, 0, 2'd2, 20'h33333, 4'b0111, 16'h0012, 2'd3};
    vecs[3] = '{1, 0, 2'd3, 20'h44444, 4'b1111, 16'h0123, 2'd0};
    vecs[4] = '{0, 1, 2'd0, 20'h0,     4'b1111, 16'h1230, 2'd1};
    vecs[5] = '{0, 1, 2'd3, 20'h0,     4'b1111, 16'h0341, 2'd1};

    rst_n = 1'b0; rd_set = '0; idle();
    wr_set = '0; wr_way = '0; wr_vpn = '0; wr_ppn = '0; wr_perms = '0; wr_asid = '0;
    wr_global = 1'b0; touch_set = '0; touch_way = '0; flush_mode = '0; flush_asid = '0;
    flush_set = '0;

    // Reset state across every set.
    do_reset();
    check("rst_ready", ready, 1'b1);
    check("rst_busy", flush_busy, 1'b0);
    check("rst_done", flush_done, 1'b0);
    for (int s = 0; s < NS; s++) begin
      rd_set = 4'(s);
      #1;
      check("rst_valid", rd_valid, 4'b0);
      check("rst_lru", rd_lru, 16'h0);
      check("rst_victim", victim_way, 2'd0);
    end

    // Fill and touch set 3 from the vector table.
    rd_set = 4'd3;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (vecs[i].wr) write(3, int'(vecs[i].way), vecs[i].vpn, 8'h0, 1'b0);
      touch_en = vecs[i].tc; touch_set = 4'd3; touch_way = vecs[i].way;
      cycle();
      check("vec_valid", rd_valid, vecs[i].exp_valid);
      check("vec_lru", rd_lru, vecs[i].exp_lru);
      check("vec_victim", victim_way, vecs[i].exp_victim);
      if (vecs[i].wr) check("vec_vpn", rd_vpn[vecs[i].way*20 +: 20], vecs[i].vpn);
    end
    // Saturation: ages pin at 15 and the victim tie goes to the lowest way.
    idle();
    touch_en = 1'b1; touch_set = 4'd3; touch_way = 2'd0;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_lru", rd_lru, 16'hfff0);
    check("sat_victim", victim_way, 2'd1);

    // Same-cycle write and touch.
    idle(); rd_set = 4'd8;
    write(8, 2, 20'h80002, 8'h0, 1'b0); cycle();
    write(8, 1, 20'h80001, 8'h0, 1'b0); touch_en = 1'b1; touch_set = 4'd8; touch_way = 2'd2;
    cycle();
    check("same_set_valid", rd_valid, 4'b0110);
    check("same_set_lru", rd_lru, 16'h0100);
    idle();
    write(9, 0, 20'h90000, 8'h0, 1'b0); cycle();
    write(9, 1, 20'h90001, 8'h0, 1'b0); cycle();
    write(8, 3, 20'h80003, 8'h0, 1'b0); touch_en = 1'b1; touch_set = 4'd9; touch_way = 2'd0;
    cycle();
    check("diff_set_lru8", rd_lru, 16'h0210);
    check("diff_set_valid8", rd_valid, 4'b1110);
    idle();
    rd_set = 4'd9; #1;
    check("diff_set_lru9", rd_lru, 16'h0010);

    // ASID flush across all sets with one global survivor.
    do_reset();
    for (int s = 0; s < NS; s++) begin
      write(s, 0, 20'(s), 8'd5, 1'b0); cycle();
    end
    write(2, 1, 20'h22221, 8'd5, 1'b1); cycle();
    idle();
    flush_req = 1'b1; flush_mode = 2'b01; flush_asid = 8'd5;
    cycle();
    idle();
    busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      if (flush_busy) busy_cnt++;
      if (flush_done) done_at = i;
      else cycle();
    end
    check("flush01_busy_cycles", busy_cnt, 16);
    check("flush01_done_at", done_at, 17);
    cycle();
    check("flush01_done_pulse", flush_done, 1'b0);
    nvalid = 0;
    for (int s = 0; s < NS; s++) begin
      rd_set = 4'(s); #1;
      nvalid += $countones(rd_valid);
    end
    check("flush01_survivors", nvalid, 1);
    rd_set = 4'd2; #1;
    check("flush01_global_kept", rd_valid, 4'b0010);

    // Single-set flush with a write held during the busy cycle.
    idle();
    write(4, 0, 20'h40000, 8'd1, 1'b0); cycle();
    write(4, 1, 20'h40001, 8'd1, 1'b0); cycle();
    idle();
    flush_req = 1'b1; flush_mode = 2'b10; flush_set = 4'd4;
    cycle();
    check("flush10_busy", flush_busy, 1'b1);
    check("flush10_ready", ready, 1'b0);
    idle();
    write(5, 2, 20'habcde, 8'd1, 1'b0); rd_set = 4'd5;
    cycle();
    check("flush10_done", flush_done, 1'b1);
    check("flush10_ready_done", ready, 1'b1);
    check("held_wr_ignored", rd_valid, 4'b0000);
    cycle();
    check("held_wr_applied", rd_valid, 4'b0100);
    check("flush10_done_end", flush_done, 1'b0);
    idle();
    rd_set = 4'd4; #1;
    check("flush10_cleared", rd_valid, 4'b0000);

    // Reset during a full flush walk aborts it.
    write(7, 3, 20'h77773, 8'd2, 1'b1); cycle();
    idle();
    flush_req = 1'b1; flush_mode = 2'b00;
    cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("abort_ready", ready, 1'b1);
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (flush_done) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 1'b0);
    nvalid = 0;
    for (int s = 0; s < NS; s++) begin
      rd_set = 4'(s); #1;
      nvalid += $countones(rd_valid);
    end
    check("abort_all_invalid", nvalid, 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_set     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      wr_way     = 2'($urandom);
      wr_vpn     = 20'($urandom);
      wr_ppn     = 20'($urandom);
      wr_perms   = 2'($urandom);
      wr_asid    = 8'($urandom_range(0, 3));
      wr_global  = ($urandom_range(0, 3) == 0);
      touch_en   = ($urandom_range(0, 1) == 0);
      touch_set  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      touch_way  = 2'($urandom);
      flush_req  = ($urandom_range(0, 39) == 0);
      flush_mode = 2'($urandom);
      flush_asid = 8'($urandom_range(0, 3));
      flush_set  = 4'($urandom_range(0, 3));
      rd_set     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      cycle();
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
